// File: rtl/pwm_servo_decoder.sv
// rtl/pwm_servo_decoder.sv - servo PWM receiver: measures high time and period, decodes a signed angle (optional 4-pulse averaging via PWM_DEC_AVG_EN)
module pwm_servo_decoder #(
  parameter int FREQ        = 25_000_000,
  parameter int TARGET_FREQ = 10,
  parameter int BIT_SIZE    = 10,
  parameter int DC_MIN      = 25_000,
  parameter int DC_MID      = 75_000,
  parameter int DC_MAX      = 125_000,
  parameter int COORD_MAX   = 270,
  parameter int RANGE_TOL   = 2_000,
  parameter int TIMEOUT     = 5_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pwm_in,
  output logic signed [BIT_SIZE-1:0] angle,
  output logic [31:0]                high_cycles,
  output logic [31:0]                period_cycles,
  output logic                       valid,
  output logic                       range_err,
  output logic                       signal_lost
);

  localparam logic [31:0] W_MIN   = 32'(DC_MIN);
  localparam logic [31:0] W_MID   = 32'(DC_MID);
  localparam logic [31:0] W_MAX   = 32'(DC_MAX);
  localparam logic [31:0] ERR_LO  = 32'(DC_MIN - RANGE_TOL);
  localparam logic [31:0] ERR_HI  = 32'(DC_MAX + RANGE_TOL);
  localparam logic [31:0] SPAN_HI = 32'(DC_MAX - DC_MID);
  localparam logic [31:0] SPAN_LO = 32'(DC_MID - DC_MIN);
  localparam logic [31:0] K_COORD = 32'(COORD_MAX);
  localparam logic [31:0] TO_LIM  = 32'(TIMEOUT);
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;
  localparam int unused_nominal_period = FREQ / TARGET_FREQ;

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t        state, state_nxt;
  logic          sync1, pwm_s, pwm_d;
  logic [1:0]    warm;
  logic          rise, fall;
  logic [31:0]   hcnt, pcnt, idle_cnt;
  logic          timeout_hit;
  logic          load_cnt, latch_high, latch_period;
  logic          lat_stb;
  logic [31:0]   map_w;
  logic          map_ok;
  logic [31:0]   w_clamp, mag;
  logic [BIT_SIZE-1:0] ang_mag;
  logic signed [BIT_SIZE-1:0] angle_nxt;
  logic          unused_mag;

  // two-flop synchronizer plus a delayed copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      pwm_s <= 1'b0;
      pwm_d <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      pwm_s <= sync1;
      pwm_d <= pwm_s;
    end
  end

  // reset zeroes the pipe, so a line already high would look like a rise until pwm_d holds a real sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) warm <= 2'd0;
    else if (warm != 2'd3) warm <= warm + 2'd1;
  end

  assign rise = pwm_s & ~pwm_d & (warm == 2'd3);
  assign fall = ~pwm_s & pwm_d;
  assign timeout_hit = !rise && !fall && (idle_cnt >= TO_LIM - 32'd1);

  // idle counter: cleared by any edge, saturates at TIMEOUT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_cnt <= '0;
    else if (rise || fall) idle_cnt <= '0;
    else if (idle_cnt < TO_LIM) idle_cnt <= idle_cnt + 32'd1;
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end

  // next state and latch strobes; a timeout forces IDLE unless a rise arrives the same cycle
  always_comb begin
    state_nxt    = state;
    load_cnt     = 1'b0;
    latch_high   = 1'b0;
    latch_period = 1'b0;
    case (state)
      IDLE: if (rise) begin
        state_nxt = HIGH;
        load_cnt  = 1'b1;
      end
      HIGH: if (fall) begin
        state_nxt  = LOW;
        latch_high = 1'b1;
      end
      LOW: if (rise) begin
        state_nxt    = HIGH;
        load_cnt     = 1'b1;
        latch_period = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
    if (timeout_hit) state_nxt = IDLE;
  end

  // saturating high-time and period counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
      pcnt <= '0;
    end else if (load_cnt) begin
      hcnt <= 32'd1;
      pcnt <= 32'd1;
    end else begin
      if (state == HIGH && hcnt != CNT_MAX) hcnt <= hcnt + 32'd1;
      if (state != IDLE && pcnt != CNT_MAX) pcnt <= pcnt + 32'd1;
    end
  end

  // measurement latches and link status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      high_cycles   <= '0;
      period_cycles <= '0;
      lat_stb       <= 1'b0;
      signal_lost   <= 1'b1;
    end else begin
      lat_stb <= latch_high;
      if (latch_high) high_cycles <= hcnt;
      if (latch_period) begin
        period_cycles <= pcnt;
        signal_lost   <= 1'b0;
      end else if (timeout_hit) begin
        signal_lost <= 1'b1;
      end
    end
  end

`ifdef PWM_DEC_AVG_EN
  logic [31:0] hist [4];
  logic [2:0]  avg_cnt;
  logic [33:0] avg_sum;
  logic        unused_avg;

  // keep the last four raw high times; the fill count restarts after reset or signal loss
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) hist[i] <= '0;
      avg_cnt <= 3'd0;
    end else if (timeout_hit) begin
      avg_cnt <= 3'd0;
    end else if (latch_high) begin
      hist[0] <= hcnt;
      hist[1] <= hist[0];
      hist[2] <= hist[1];
      hist[3] <= hist[2];
      if (avg_cnt != 3'd4) avg_cnt <= avg_cnt + 3'd1;
    end
  end

  assign avg_sum    = {2'b00, hist[0]} + {2'b00, hist[1]} + {2'b00, hist[2]} + {2'b00, hist[3]};
  assign map_w      = avg_sum[33:2];
  assign map_ok     = (avg_cnt == 3'd4);
  assign unused_avg = ^avg_sum[1:0];
`else
  assign map_w  = high_cycles;
  assign map_ok = 1'b1;
`endif

  // inverse duty-cycle map: clamp, scale the magnitude, negate below the midpoint
  always_comb begin
    w_clamp = map_w;
    if (map_w < W_MIN) w_clamp = W_MIN;
    else if (map_w > W_MAX) w_clamp = W_MAX;
    if (w_clamp >= W_MID) begin
      mag       = ((w_clamp - W_MID) * K_COORD) / SPAN_HI;
      ang_mag   = mag[BIT_SIZE-1:0];
      angle_nxt = ang_mag;
    end else begin
      mag       = ((W_MID - w_clamp) * K_COORD) / SPAN_LO;
      ang_mag   = mag[BIT_SIZE-1:0];
      angle_nxt = -ang_mag;
    end
  end

  assign unused_mag = ^mag[31:BIT_SIZE];

  // mapping stage: one cycle after the latch, with the sticky range check on the raw pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      angle     <= '0;
      valid     <= 1'b0;
      range_err <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (lat_stb) begin
        if (high_cycles < ERR_LO || high_cycles > ERR_HI) range_err <= 1'b1;
        if (map_ok) begin
          angle <= angle_nxt;
          valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_servo_decoder.sv
// tb/tb_pwm_servo_decoder.sv - randomized self-checking bench for pwm_servo_decoder with scaled timing
module tb_pwm_servo_decoder;

  localparam int BIT_SIZE  = 10;
  localparam int DC_MIN    = 250;
  localparam int DC_MID    = 750;
  localparam int DC_MAX    = 1250;
  localparam int COORD_MAX = 270;
  localparam int RANGE_TOL = 20;
  localparam int TIMEOUT   = 5000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pwm_in = 1'b0;
  logic signed [BIT_SIZE-1:0] angle;
  logic [31:0] high_cycles, period_cycles;
  logic valid, range_err, signal_lost;

  typedef struct {
    int ang;
    int hi;
    int cyc;
  } ev_t;

  ev_t vq[$];
  int  cyc = 0;
  int  fall_edge = 0;
  int  checks = 0;
  int  failures = 0;
  bit  model_err = 1'b0;

  pwm_servo_decoder #(
    .FREQ(25_000_000), .TARGET_FREQ(10), .BIT_SIZE(BIT_SIZE),
    .DC_MIN(DC_MIN), .DC_MID(DC_MID), .DC_MAX(DC_MAX),
    .COORD_MAX(COORD_MAX), .RANGE_TOL(RANGE_TOL), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in), .angle(angle),
    .high_cycles(high_cycles), .period_cycles(period_cycles),
    .valid(valid), .range_err(range_err), .signal_lost(signal_lost)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) vq.push_back('{ang: int'(angle), hi: int'(high_cycles), cyc: cyc});
  end

  function automatic int ref_angle(int w);
    int c;
    c = (w < DC_MIN) ? DC_MIN : ((w > DC_MAX) ? DC_MAX : w);
    if (c >= DC_MID) return ((c - DC_MID) * COORD_MAX) / (DC_MAX - DC_MID);
    return -(((DC_MID - c) * COORD_MAX) / (DC_MID - DC_MIN));
  endfunction

  function automatic bit ref_err(int w);
    return (w < DC_MIN - RANGE_TOL) || (w > DC_MAX + RANGE_TOL);
  endfunction

  task automatic wait_cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pulse(int h, int l);
    pwm_in = 1'b1;
    wait_cycles(h);
    pwm_in = 1'b0;
    fall_edge = cyc + 1;
    wait_cycles(l);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    pwm_in = 1'b0;
    wait_cycles(4);
    checks += 6;
    if (angle !== '0) begin failures++; $display("FAIL reset_angle: got %0d expected 0", angle); end
    if (high_cycles !== 32'd0) begin failures++; $display("FAIL reset_high: got %0d expected 0", high_cycles); end
    if (period_cycles !== 32'd0) begin failures++; $display("FAIL reset_period: got %0d expected 0", period_cycles); end
    if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", valid); end
    if (range_err !== 1'b0) begin failures++; $display("FAIL reset_range_err: got %0b expected 0", range_err); end
    if (signal_lost !== 1'b1) begin failures++; $display("FAIL reset_signal_lost: got %0b expected 1", signal_lost); end
    rst = 1'b0;
    model_err = 1'b0;
    wait_cycles(8);
    vq.delete();
  endtask

  task automatic test_center;
    ev_t e;
    for (int i = 0; i < 3; i++) begin
      send_pulse(750, 1750);
      checks++;
      if (vq.size() != 1) begin
        failures++; $display("FAIL center_valid_count: got %0d expected 1", vq.size());
      end else begin
        e = vq.pop_front();
        checks += 3;
        if (e.ang != 0) begin failures++; $display("FAIL center_angle: got %0d expected 0", e.ang); end
        if (e.hi != 750) begin failures++; $display("FAIL center_high: got %0d expected 750", e.hi); end
        if (e.cyc != fall_edge + 3) begin failures++; $display("FAIL center_latency: got %0d expected %0d", e.cyc, fall_edge + 3); end
      end
      vq.delete();
      checks++;
      if (signal_lost !== (i == 0)) begin failures++; $display("FAIL center_signal_lost: got %0b expected %0b", signal_lost, i == 0); end
      if (i > 0) begin
        checks++;
        if (period_cycles !== 32'd2500) begin failures++; $display("FAIL center_period: got %0d expected 2500", period_cycles); end
      end
    end
  endtask

  task automatic test_table;
    int hs[4] = '{1250, 250, 1000, 500};
    ev_t e;
    foreach (hs[i]) begin
      send_pulse(hs[i], 2000 - hs[i]);
      checks++;
      if (vq.size() != 1) begin
        failures++; $display("FAIL table_valid_count: got %0d expected 1", vq.size());
      end else begin
        e = vq.pop_front();
        checks++;
        if (e.ang != ref_angle(hs[i])) begin failures++; $display("FAIL table_angle: got %0d expected %0d", e.ang, ref_angle(hs[i])); end
      end
      vq.delete();
      checks++;
      if (range_err !== 1'b0) begin failures++; $display("FAIL table_range_err: got %0b expected 0", range_err); end
    end
  endtask

  task automatic test_random;
    int h, l, prev_period;
    ev_t e;
    prev_period = 2000;
    for (int i = 0; i < 8; i++) begin
      h = int'($urandom_range(DC_MAX + RANGE_TOL, DC_MIN - RANGE_TOL));
      l = int'($urandom_range(1200, 300));
      send_pulse(h, l);
      checks += 3;
      if (vq.size() != 1) begin
        failures++; $display("FAIL random_valid_count: got %0d expected 1", vq.size());
      end else begin
        e = vq.pop_front();
        checks += 2;
        if (e.ang != ref_angle(h)) begin failures++; $display("FAIL random_angle: got %0d expected %0d (w=%0d)", e.ang, ref_angle(h), h); end
        if (e.hi != h) begin failures++; $display("FAIL random_high: got %0d expected %0d", e.hi, h); end
        if (e.cyc != fall_edge + 3) begin failures++; $display("FAIL random_latency: got %0d expected %0d", e.cyc, fall_edge + 3); end
      end
      vq.delete();
      if (period_cycles !== 32'(prev_period)) begin failures++; $display("FAIL random_period: got %0d expected %0d", period_cycles, prev_period); end
      if (range_err !== 1'b0) begin failures++; $display("FAIL random_range_err: got %0b expected 0", range_err); end
      prev_period = h + l;
    end
  endtask

  task automatic test_boundaries;
    int hs[5] = '{230, 1270, 229, 1000, 200};
    ev_t e;
    foreach (hs[i]) begin
      send_pulse(hs[i], 2000 - hs[i]);
      model_err = model_err | ref_err(hs[i]);
      checks++;
      if (vq.size() != 1) begin
        failures++; $display("FAIL bound_valid_count: got %0d expected 1", vq.size());
      end else begin
        e = vq.pop_front();
        checks++;
        if (e.ang != ref_angle(hs[i])) begin failures++; $display("FAIL bound_angle: got %0d expected %0d (w=%0d)", e.ang, ref_angle(hs[i]), hs[i]); end
      end
      vq.delete();
      checks++;
      if (range_err !== model_err) begin failures++; $display("FAIL bound_range_err: got %0b expected %0b (w=%0d)", range_err, model_err, hs[i]); end
    end
  endtask

  task automatic test_timeout;
    ev_t e;
    send_pulse(600, 1400);
    wait_cycles(TIMEOUT);
    vq.delete();
    checks += 2;
    if (signal_lost !== 1'b1) begin failures++; $display("FAIL timeout_signal_lost: got %0b expected 1", signal_lost); end
    if (period_cycles !== 32'd2000) begin failures++; $display("FAIL timeout_period_hold: got %0d expected 2000", period_cycles); end
    send_pulse(1000, 1200);
    checks += 3;
    if (vq.size() != 1) begin
      failures++; $display("FAIL timeout_first_valid_count: got %0d expected 1", vq.size());
    end else begin
      e = vq.pop_front();
      checks++;
      if (e.ang != ref_angle(1000)) begin failures++; $display("FAIL timeout_first_angle: got %0d expected %0d", e.ang, ref_angle(1000)); end
    end
    vq.delete();
    if (signal_lost !== 1'b1) begin failures++; $display("FAIL timeout_lost_after_one: got %0b expected 1", signal_lost); end
    if (period_cycles !== 32'd2000) begin failures++; $display("FAIL timeout_period_idle: got %0d expected 2000", period_cycles); end
    send_pulse(500, 1500);
    vq.delete();
    checks += 2;
    if (signal_lost !== 1'b0) begin failures++; $display("FAIL timeout_recover: got %0b expected 0", signal_lost); end
    if (period_cycles !== 32'd2200) begin failures++; $display("FAIL timeout_new_period: got %0d expected 2200", period_cycles); end
  endtask

  task automatic test_reset_mid_pulse;
    ev_t e;
    pwm_in = 1'b1;
    wait_cycles(300);
    rst = 1'b1;
    #1;
    checks += 4;
    if (valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %0b expected 0", valid); end
    if (signal_lost !== 1'b1) begin failures++; $display("FAIL midrst_signal_lost: got %0b expected 1", signal_lost); end
    if (high_cycles !== 32'd0) begin failures++; $display("FAIL midrst_high: got %0d expected 0", high_cycles); end
    if (range_err !== 1'b0) begin failures++; $display("FAIL midrst_range_err: got %0b expected 0", range_err); end
    wait_cycles(3);
    rst = 1'b0;
    model_err = 1'b0;
    vq.delete();
    wait_cycles(400);
    pwm_in = 1'b0;
    wait_cycles(1300);
    checks++;
    if (vq.size() != 0) begin failures++; $display("FAIL midrst_partial_valid: got %0d expected 0", vq.size()); end
    vq.delete();
    send_pulse(500, 1500);
    checks++;
    if (vq.size() != 1) begin
      failures++; $display("FAIL midrst_next_valid_count: got %0d expected 1", vq.size());
    end else begin
      e = vq.pop_front();
      checks += 2;
      if (e.ang != ref_angle(500)) begin failures++; $display("FAIL midrst_angle: got %0d expected %0d", e.ang, ref_angle(500)); end
      if (e.cyc != fall_edge + 3) begin failures++; $display("FAIL midrst_latency: got %0d expected %0d", e.cyc, fall_edge + 3); end
    end
    vq.delete();
  endtask

  task automatic test_avg;
    int hs[7];
    int win[$];
    int sum;
    ev_t e;
    hs[0] = 750; hs[1] = 750; hs[2] = 1250; hs[3] = 1250;
    for (int i = 4; i < 7; i++) hs[i] = int'($urandom_range(DC_MAX, DC_MIN));
    foreach (hs[i]) begin
      send_pulse(hs[i], 1000);
      win.push_back(hs[i]);
      if (win.size() > 4) void'(win.pop_front());
      checks++;
      if (i < 3) begin
        if (vq.size() != 0) begin failures++; $display("FAIL avg_early_valid: got %0d expected 0 (pulse %0d)", vq.size(), i); end
      end else if (vq.size() != 1) begin
        failures++; $display("FAIL avg_valid_count: got %0d expected 1", vq.size());
      end else begin
        e = vq.pop_front();
        sum = 0;
        foreach (win[k]) sum += win[k];
        checks += 2;
        if (e.ang != ref_angle(sum / 4)) begin failures++; $display("FAIL avg_angle: got %0d expected %0d", e.ang, ref_angle(sum / 4)); end
        if (e.hi != hs[i]) begin failures++; $display("FAIL avg_raw_high: got %0d expected %0d", e.hi, hs[i]); end
      end
      vq.delete();
    end
  endtask

  initial begin
    test_reset;
`ifdef PWM_DEC_AVG_EN
    test_avg;
`else
    test_center;
    test_table;
    test_random;
    test_boundaries;
    test_timeout;
    test_reset_mid_pulse;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
